regbank_sequencer: RTL and testbench
====================================

# regbank_sequencer

Command-driven controller for the two-read-port/one-write-port register bank of the CPU datapath. It accepts single micro-operations over a valid/ready command interface and drives the bank's data-bus and secondary-bus select, enable and load lines. It captures read data and returns a response (data, carry, error) over a valid/ready response interface. It sits between the instruction decoder / debug port and the register bank, and it is the only block that asserts the bank's load strobe.

## Interface
- DATA_WIDTH, 8, register and data bus width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  0 NOP, 1 LOAD, 2 MOVE, 3 SWAP, 4 READ, 5 ADD, 6–7 reserved
- cmd_src  in  2  source register index
- cmd_dst  in  2  destination register index
- cmd_imm  in  DATA_WIDTH  immediate for LOAD
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_data  out  DATA_WIDTH  result value
- rsp_carry  out  1  ADD carry-out; 0 for all other ops
- rsp_err  out  1  reserved opcode
- rb_dbi  out  DATA_WIDTH  write data to bank
- rb_db  in  DATA_WIDTH  bank data-bus read value (combinational from rb_dba)
- rb_dba  out  2  bank data-bus address
- rb_dbe  out  1  bank data-bus enable
- rb_dbld  out  1  bank load strobe; writes rb_dbi to register rb_dba at the next edge
- rb_sb  in  DATA_WIDTH  bank secondary-bus read value
- rb_sba  out  2  bank secondary-bus address
- rb_sbe  out  1  bank secondary-bus enable

## Operation
- States: IDLE, RD, WR1, WR2, RSP.
- IDLE: cmd_ready=1. On accept, latch op/src/dst/imm. Next state: NOP/reserved → RSP; LOAD → WR1; others → RD.
- RD: rb_dbe=1, rb_dba=src. For SWAP and ADD, also rb_sbe=1, rb_sba=dst. At the edge, ta<=rb_db and tb<=rb_sb. Next state: READ → RSP; MOVE/ADD/SWAP → WR1.
- WR1: rb_dbld=1, rb_dba=dst. rb_dbi is imm (LOAD), ta (MOVE, SWAP) or ta+tb (ADD, low DATA_WIDTH bits). For ADD, latch carry = bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum. Next state: SWAP → WR2; others → RSP.
- WR2 (SWAP only): rb_dbld=1, rb_dba=src, rb_dbi=tb. Next state: RSP.
- RSP: rsp_valid=1. Hold all rsp_* stable until rsp_ready, then go to IDLE.
- rsp_data per op: LOAD imm; MOVE ta; SWAP ta; READ ta; ADD sum; NOP/reserved 0. rsp_err=1 only for ops 6–7.
- Bank control outputs are 0 in IDLE and RSP. rb_dbe and rb_dbld are never both 1. rb_dbi=0 whenever rb_dbld=0.
- Aliasing: SWAP with src==dst leaves the register unchanged (two writes of the same value). ADD with src==dst yields 2·r.

## Timing
- Accept at edge T. Response appears at: LOAD T+2; READ T+2; MOVE T+3; ADD T+3; SWAP T+4; NOP/reserved T+1.
- rsp_valid is asserted from the edge that enters RSP. It holds over any number of rsp_ready=0 cycles.
- When rsp_ready is 1 in the first RSP cycle, cmd_ready=1 on the following cycle. Back-to-back throughput is one command per (latency+1) cycles.
- No command is accepted outside IDLE. cmd_ready is combinational: (state==IDLE) & ~rst.
- Reset (while rst=1 and after):
  - state=IDLE; ta, tb, carry and all latched command fields are 0.
  - rsp_valid, rsp_data, rsp_carry and rsp_err are 0.
  - All rb_* outputs are 0. rb_dbld is gated by ~rst, so no bank write occurs in a reset cycle.
- Reset mid-operation aborts the command: no further writes, no response. A SWAP aborted between WR1 and WR2 leaves dst written and src unchanged.

## Test plan
- Reset, then LOAD r2←0xA5: rb_dbld=1 with rb_dba=2 and rb_dbi=0xA5 in the cycle after accept. rsp_valid at T+2 with rsp_data=0xA5 and rsp_err=0.
- LOAD r0=0x12, r1=0x34, then SWAP src=0 dst=1: WR1 writes 0x12 to r1, WR2 writes 0x34 to r0. rsp_data=0x12 at T+4. READ r0 then returns 0x34.
- r1=0xF0, r3=0x20, ADD src=1 dst=3: r3←0x10, rsp_data=0x10, rsp_carry=1. ADD of 0x01+0x02 gives 0x03 with rsp_carry=0.
- READ with rsp_ready held 0 for 5 cycles: rsp_valid and rsp_data are stable throughout, cmd_ready=0 and cmd_valid is ignored. Then one rsp_ready pulse → IDLE.
- cmd_op=7: rsp_valid at T+1 with rsp_err=1 and rsp_data=0. No rb_dbe, rb_sbe or rb_dbld pulse is seen.
- Assert rst during the WR2 cycle of a SWAP: no rb_dbld in that cycle, src register is unchanged, no rsp_valid, and cmd_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/regbank_sequencer.sv
// Command-driven sequencer for the 2R/1W register bank.
// Issues bank read/write strobes per micro-op and returns a response.
module regbank_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [1:0]            cmd_src,
  input  logic [1:0]            cmd_dst,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_carry,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rb_dbi,
  input  logic [DATA_WIDTH-1:0] rb_db,
  output logic [1:0]            rb_dba,
  output logic                  rb_dbe,
  output logic                  rb_dbld,
  input  logic [DATA_WIDTH-1:0] rb_sb,
  output logic [1:0]            rb_sba,
  output logic                  rb_sbe
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_MOVE = 3'd2;
  localparam logic [2:0] OP_SWAP = 3'd3;
  localparam logic [2:0] OP_READ = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR1, S_WR2, S_RSP
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q;
  logic [1:0]            src_q, dst_q;
  logic [DATA_WIDTH-1:0] imm_q, ta_q, tb_q;
  logic                  carry_q;
  logic [DATA_WIDTH:0]   sum;
  logic                  accept;
  logic                  rsvd;

  assign accept = cmd_valid & cmd_ready;
  assign sum    = {1'b0, ta_q} + {1'b0, tb_q};
  assign rsvd   = (op_q[2:1] == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      ta_q    <= '0;
      tb_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= cmd_op;
        src_q   <= cmd_src;
        dst_q   <= cmd_dst;
        imm_q   <= cmd_imm;
        carry_q <= 1'b0;
      end
      if (state_q == S_RD) begin
        ta_q <= rb_db;
        tb_q <= rb_sb;
      end
      if (state_q == S_WR1 && op_q == OP_ADD)
        carry_q <= sum[DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_NOP || cmd_op[2:1] == 2'b11)
            state_d = S_RSP;
          else if (cmd_op == OP_LOAD)
            state_d = S_WR1;
          else
            state_d = S_RD;
        end
      end
      S_RD:  state_d = (op_q == OP_READ) ? S_RSP : S_WR1;
      S_WR1: state_d = (op_q == OP_SWAP) ? S_WR2 : S_RSP;
      S_WR2: state_d = S_RSP;
      S_RSP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is forced low in a reset cycle, even mid-operation.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_carry = 1'b0;
    rsp_err   = 1'b0;
    rb_dbi    = '0;
    rb_dba    = '0;
    rb_dbe    = 1'b0;
    rb_dbld   = 1'b0;
    rb_sba    = '0;
    rb_sbe    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: cmd_ready = 1'b1;
        S_RD: begin
          rb_dbe = 1'b1;
          rb_dba = src_q;
          if (op_q == OP_SWAP || op_q == OP_ADD) begin
            rb_sbe = 1'b1;
            rb_sba = dst_q;
          end
        end
        S_WR1: begin
          rb_dbld = 1'b1;
          rb_dba  = dst_q;
          if (op_q == OP_LOAD)     rb_dbi = imm_q;
          else if (op_q == OP_ADD) rb_dbi = sum[DATA_WIDTH-1:0];
          else                     rb_dbi = ta_q;
        end
        S_WR2: begin
          rb_dbld = 1'b1;
          rb_dba  = src_q;
          rb_dbi  = tb_q;
        end
        S_RSP: begin
          rsp_valid = 1'b1;
          rsp_carry = carry_q;
          rsp_err   = rsvd;
          if (op_q == OP_LOAD)
            rsp_data = imm_q;
          else if (op_q == OP_ADD)
            rsp_data = sum[DATA_WIDTH-1:0];
          else if (op_q == OP_MOVE || op_q == OP_SWAP || op_q == OP_READ)
            rsp_data = ta_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_sequencer.sv
// Directed bench for regbank_sequencer with a behavioural register bank.
// Vector table plus hand sequences for stall, reserved op and reset abort.
module tb_regbank_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_src, cmd_dst;
  logic [7:0] cmd_imm;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry, rsp_err;
  logic [7:0] rb_dbi, rb_db, rb_sb;
  logic [1:0] rb_dba, rb_sba;
  logic       rb_dbe, rb_dbld, rb_sbe;

  logic [7:0] bank [4];
  int         checks = 0;
  int         errors = 0;
  int         strobes = 0;

  always #5 clk = ~clk;

  regbank_sequencer #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .rsp_err(rsp_err),
    .rb_dbi(rb_dbi), .rb_db(rb_db), .rb_dba(rb_dba),
    .rb_dbe(rb_dbe), .rb_dbld(rb_dbld),
    .rb_sb(rb_sb), .rb_sba(rb_sba), .rb_sbe(rb_sbe)
  );

  assign rb_db = bank[rb_dba];
  assign rb_sb = bank[rb_sba];

  always @(posedge clk) if (rb_dbld) bank[rb_dba] <= rb_dbi;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rb_dbe | rb_sbe | rb_dbld) strobes++;
    chk("dbe_dbld_excl", int'(rb_dbe & rb_dbld), 0);
    if (!rb_dbld) chk("dbi_zero", int'(rb_dbi), 0);
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [7:0] imm;
    logic [7:0] data;
    logic       carry;
    logic       err;
    int         lat;
    int         stall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] op,
      input logic [1:0] s, input logic [1:0] d,
      input logic [7:0] imm, input logic [7:0] data,
      input logic c, input logic e, input int lat,
      input int stall);
    vec_t v;
    v.op = op; v.src = s; v.dst = d; v.imm = imm;
    v.data = data; v.carry = c; v.err = e;
    v.lat = lat; v.stall = stall;
    return v;
  endfunction

  task automatic run(input vec_t t);
    int edges;
    @(negedge clk);
    chk("ready_idle", int'(cmd_ready), 1);
    cmd_op = t.op; cmd_src = t.src;
    cmd_dst = t.dst; cmd_imm = t.imm;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    edges = 1;
    if (t.op == 3'd1) begin
      chk("load_dbld", int'(rb_dbld), 1);
      chk("load_dba", int'(rb_dba), int'(t.dst));
      chk("load_dbi", int'(rb_dbi), int'(t.imm));
    end
    while (!rsp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, t.lat);
    chk("rsp_data", int'(rsp_data), int'(t.data));
    chk("rsp_carry", int'(rsp_carry), int'(t.carry));
    chk("rsp_err", int'(rsp_err), int'(t.err));
    for (int i = 0; i < t.stall; i++) begin
      cmd_op = 3'd1; cmd_dst = t.src;
      cmd_imm = 8'hFF; cmd_valid = 1'b1;
      @(posedge clk); #1;
      chk("stall_valid", int'(rsp_valid), 1);
      chk("stall_data", int'(rsp_data), int'(t.data));
      chk("stall_ready", int'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("ready_after", int'(cmd_ready), 1);
    chk("valid_after", int'(rsp_valid), 0);
  endtask

  initial begin
    int s0;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_imm = '0;

    tbl.push_back(mk(3'd1, 0, 2, 8'hA5, 8'hA5, 0, 0, 2, 0));
    tbl.push_back(mk(3'd1, 0, 0, 8'h12, 8'h12, 0, 0, 2, 0));
    tbl.push_back(mk(3'd1, 0, 1, 8'h34, 8'h34, 0, 0, 2, 0));
    tbl.push_back(mk(3'd3, 0, 1, 8'h00, 8'h12, 0, 0, 4, 0));
    tbl.push_back(mk(3'd4, 0, 0, 8'h00, 8'h34, 0, 0, 2, 0));
    tbl.push_back(mk(3'd4, 1, 0, 8'h00, 8'h12, 0, 0, 2, 0));
    tbl.push_back(mk(3'd1, 0, 1, 8'hF0, 8'hF0, 0, 0, 2, 0));
    tbl.push_back(mk(3'd1, 0, 3, 8'h20, 8'h20, 0, 0, 2, 0));
    tbl.push_back(mk(3'd5, 1, 3, 8'h00, 8'h10, 1, 0, 3, 0));
    tbl.push_back(mk(3'd4, 3, 0, 8'h00, 8'h10, 0, 0, 2, 0));
    tbl.push_back(mk(3'd1, 0, 0, 8'h01, 8'h01, 0, 0, 2, 0));
    tbl.push_back(mk(3'd1, 0, 1, 8'h02, 8'h02, 0, 0, 2, 0));
    tbl.push_back(mk(3'd5, 0, 1, 8'h00, 8'h03, 0, 0, 3, 0));
    tbl.push_back(mk(3'd4, 1, 0, 8'h00, 8'h03, 0, 0, 2, 0));
    tbl.push_back(mk(3'd2, 2, 0, 8'h00, 8'hA5, 0, 0, 3, 0));
    tbl.push_back(mk(3'd4, 0, 0, 8'h00, 8'hA5, 0, 0, 2, 0));
    tbl.push_back(mk(3'd0, 1, 2, 8'h77, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(3'd6, 1, 2, 8'h77, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(3'd3, 2, 2, 8'h00, 8'hA5, 0, 0, 4, 0));
    tbl.push_back(mk(3'd4, 2, 0, 8'h00, 8'hA5, 0, 0, 2, 0));
    tbl.push_back(mk(3'd5, 2, 2, 8'h00, 8'h4A, 1, 0, 3, 0));
    tbl.push_back(mk(3'd4, 2, 0, 8'h00, 8'h4A, 0, 0, 2, 5));
    tbl.push_back(mk(3'd4, 2, 0, 8'h00, 8'h4A, 0, 0, 2, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_bank_ctl",
        int'({rb_dbe, rb_sbe, rb_dbld, rb_dba, rb_sba}), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(cmd_ready), 1);

    foreach (tbl[i]) run(tbl[i]);

    s0 = strobes;
    run(mk(3'd7, 3, 3, 8'h5A, 8'h00, 0, 1, 1, 0));
    chk("rsvd_no_strobe", strobes - s0, 0);

    run(mk(3'd1, 0, 0, 8'h11, 8'h11, 0, 0, 2, 0));
    run(mk(3'd1, 0, 1, 8'h22, 8'h22, 0, 0, 2, 0));
    @(negedge clk);
    cmd_op = 3'd3; cmd_src = 2'd0; cmd_dst = 2'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_wr1_dbld", int'(rb_dbld), 1);
    @(posedge clk); #1;
    chk("abort_wr2_dbld", int'(rb_dbld), 1);
    rst = 1'b1;
    #1;
    chk("abort_dbld_gated", int'(rb_dbld), 0);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_no_rsp", int'(rsp_valid), 0);
    chk("abort_dst", int'(bank[1]), 8'h11);
    chk("abort_src", int'(bank[0]), 8'h11);
    run(mk(3'd4, 0, 0, 8'h00, 8'h11, 0, 0, 2, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
